// File: rtl/wb_arbiter_2m_if.sv
// Bundle of the two master ports, the shared slave port and the arbiter status
// outputs for wb_arbiter_2m; the arbiter connects through the slave modport.
interface wb_arbiter_2m_if;
   logic        m0_cyc_i, m0_stb_i, m0_we_i;
   logic [3:0]  m0_sel_i;
   logic [31:0] m0_adr_i, m0_dat_i;
   logic        m0_ack_o, m0_err_o;
   logic [31:0] m0_dat_o;

   logic        m1_cyc_i, m1_stb_i, m1_we_i;
   logic [3:0]  m1_sel_i;
   logic [31:0] m1_adr_i, m1_dat_i;
   logic        m1_ack_o, m1_err_o;
   logic [31:0] m1_dat_o;

   logic        s_cyc_o, s_stb_o, s_we_o;
   logic [3:0]  s_sel_o;
   logic [31:0] s_adr_o, s_dat_o;
   logic        s_ack_i;
   logic [31:0] s_dat_i;

   logic [1:0]  grant_o;
   logic        timeout_o;

   modport slave (
      input  m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
      output m0_ack_o, m0_err_o, m0_dat_o,
      input  m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
      output m1_ack_o, m1_err_o, m1_dat_o,
      output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
      input  s_ack_i, s_dat_i,
      output grant_o, timeout_o
   );

   modport master (
      output m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
      input  m0_ack_o, m0_err_o, m0_dat_o,
      output m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
      input  m1_ack_o, m1_err_o, m1_dat_o,
      input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
      output s_ack_i, s_dat_i,
      input  grant_o, timeout_o
   );
endinterface

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter: round-robin on ties, bus lock while the owner
// holds cyc, and a wait-cycle watchdog that errors the owner and drains.
module wb_arbiter_2m #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_ni,
   wb_arbiter_2m_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, DRAIN} state_t;

   localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);
   localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);

   state_t      state_q, state_d;
   logic        owner_q, owner_d;
   logic        last_q, last_d;
   logic [15:0] cnt_q, cnt_d;

   logic        busy, sel, sel_cyc, drain_cyc, hit;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      busy      = (state_q == BUSY0) || (state_q == BUSY1);
      sel       = (state_q == BUSY1);
      sel_cyc   = sel ? bus.m1_cyc_i : bus.m0_cyc_i;
      drain_cyc = owner_q ? bus.m1_cyc_i : bus.m0_cyc_i;

      bus.s_cyc_o   = 1'b0;
      bus.s_stb_o   = 1'b0;
      bus.s_we_o    = 1'b0;
      bus.s_sel_o   = '0;
      bus.s_adr_o   = '0;
      bus.s_dat_o   = '0;
      bus.grant_o   = '0;
      bus.m0_ack_o  = 1'b0;
      bus.m0_err_o  = 1'b0;
      bus.m0_dat_o  = '0;
      bus.m1_ack_o  = 1'b0;
      bus.m1_err_o  = 1'b0;
      bus.m1_dat_o  = '0;
      bus.timeout_o = 1'b0;

      if (busy) begin
         bus.s_cyc_o = sel ? bus.m1_cyc_i : bus.m0_cyc_i;
         bus.s_stb_o = sel ? bus.m1_stb_i : bus.m0_stb_i;
         bus.s_we_o  = sel ? bus.m1_we_i  : bus.m0_we_i;
         bus.s_sel_o = sel ? bus.m1_sel_i : bus.m0_sel_i;
         bus.s_adr_o = sel ? bus.m1_adr_i : bus.m0_adr_i;
         bus.s_dat_o = sel ? bus.m1_dat_i : bus.m0_dat_i;
         bus.grant_o = sel ? 2'b10 : 2'b01;
      end

      // Timeout requires ack low, so ack and err are mutually exclusive by construction.
      hit = TO_EN && busy && bus.s_stb_o && !bus.s_ack_i && (cnt_q == LIMIT);
      bus.timeout_o = hit;

      if (busy) begin
         if (sel) begin
            bus.m1_ack_o = bus.s_ack_i;
            bus.m1_err_o = hit;
            bus.m1_dat_o = bus.s_dat_i;
         end else begin
            bus.m0_ack_o = bus.s_ack_i;
            bus.m0_err_o = hit;
            bus.m0_dat_o = bus.s_dat_i;
         end
      end

      cnt_d = cnt_q;
      if (!TO_EN || !bus.s_stb_o || bus.s_ack_i)
         cnt_d = '0;
      else if (cnt_q != '1)
         cnt_d = cnt_q + 16'd1;

      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (bus.m0_cyc_i && bus.m1_cyc_i) begin
               state_d = last_q ? BUSY0 : BUSY1;
               owner_d = !last_q;
            end else if (bus.m0_cyc_i) begin
               state_d = BUSY0;
               owner_d = 1'b0;
            end else if (bus.m1_cyc_i) begin
               state_d = BUSY1;
               owner_d = 1'b1;
            end
         end
         BUSY0, BUSY1: begin
            if (!sel_cyc) begin
               state_d = IDLE;
               last_d  = sel;
            end else if (hit) begin
               state_d = DRAIN;
               owner_d = sel;
            end
         end
         DRAIN: begin
            if (!drain_cyc) begin
               state_d = IDLE;
               last_d  = owner_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m (TIMEOUT_CYCLES = 4): tie-break, bus lock,
// timeout/drain, ack-at-limit, async reset abort and round-robin alternation.
module tb_wb_arbiter_2m;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   wb_arbiter_2m_if bus ();

   wb_arbiter_2m #(.TIMEOUT_CYCLES(4)) dut (
      .wb_clk_i (clk),
      .wb_rst_ni(rst_n),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.m0_we_i = 0; bus.m0_sel_i = '0;
      bus.m0_adr_i = '0; bus.m0_dat_i = '0;
      bus.m1_cyc_i = 0; bus.m1_stb_i = 0; bus.m1_we_i = 0; bus.m1_sel_i = '0;
      bus.m1_adr_i = '0; bus.m1_dat_i = '0;
      bus.s_ack_i = 0; bus.s_dat_i = '0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.s_ack_i = 1;
      #12;
      n_checks++; if (bus.grant_o !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b expected 00", bus.grant_o); end
      n_checks++; if (bus.s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL reset_s_cyc: got %b expected 0", bus.s_cyc_o); end
      n_checks++; if ({bus.m0_ack_o, bus.m0_err_o, bus.timeout_o} !== 3'b000) begin n_fail++; $display("FAIL reset_ack_err: got %b expected 000", {bus.m0_ack_o, bus.m0_err_o, bus.timeout_o}); end
      clear_inputs();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_tie();
      bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_adr_i = 32'h0000_1000;
      bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_adr_i = 32'h0000_2000;
      #1;
      n_checks++; if (bus.grant_o !== 2'b00) begin n_fail++; $display("FAIL tie_idle_grant: got %b expected 00", bus.grant_o); end
      tick();
      bus.s_ack_i = 1; bus.s_dat_i = 32'hCAFE_0001;
      #1;
      n_checks++; if (bus.grant_o !== 2'b01) begin n_fail++; $display("FAIL tie_first_grant: got %b expected 01", bus.grant_o); end
      n_checks++; if (bus.s_adr_o !== 32'h0000_1000) begin n_fail++; $display("FAIL tie_s_adr: got %h expected 00001000", bus.s_adr_o); end
      n_checks++; if (bus.m0_dat_o !== 32'hCAFE_0001 || bus.m0_ack_o !== 1'b1) begin n_fail++; $display("FAIL tie_m0_ack: got ack %b dat %h expected 1 cafe0001", bus.m0_ack_o, bus.m0_dat_o); end
      n_checks++; if (bus.m1_ack_o !== 1'b0 || bus.m1_dat_o !== 32'h0) begin n_fail++; $display("FAIL tie_m1_quiet: got ack %b dat %h expected 0 0", bus.m1_ack_o, bus.m1_dat_o); end
      tick();
      bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.s_ack_i = 0;
      tick();
      #1;
      n_checks++; if (bus.grant_o !== 2'b00) begin n_fail++; $display("FAIL tie_gap_idle: got %b expected 00", bus.grant_o); end
      tick();
      #1;
      n_checks++; if (bus.grant_o !== 2'b10) begin n_fail++; $display("FAIL tie_second_grant: got %b expected 10", bus.grant_o); end
      n_checks++; if (bus.s_adr_o !== 32'h0000_2000) begin n_fail++; $display("FAIL tie_s_adr_m1: got %h expected 00002000", bus.s_adr_o); end
      bus.m1_cyc_i = 0; bus.m1_stb_i = 0;
      tick();
      tick();
   endtask

   task automatic test_lock();
      logic [31:0] pat;
      bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_we_i = 0; bus.m0_sel_i = 4'hF;
      bus.m1_cyc_i = 1; bus.m1_stb_i = 1;
      tick();
      for (int unsigned b = 0; b < 3; b++) begin
         bus.s_ack_i = 0;
         #1;
         n_checks++; if (bus.grant_o !== 2'b01 || bus.m0_ack_o !== 1'b0) begin n_fail++; $display("FAIL lock_wait_beat%0d: got grant %b ack %b expected 01 0", b, bus.grant_o, bus.m0_ack_o); end
         tick();
         pat = 32'hA5A5_0000 + b;
         bus.s_ack_i = 1; bus.s_dat_i = pat;
         #1;
         n_checks++; if (bus.m0_ack_o !== 1'b1 || bus.m0_dat_o !== pat) begin n_fail++; $display("FAIL lock_ack_beat%0d: got ack %b dat %h expected 1 %h", b, bus.m0_ack_o, bus.m0_dat_o, pat); end
         n_checks++; if (bus.m1_ack_o !== 1'b0 || bus.grant_o !== 2'b01) begin n_fail++; $display("FAIL lock_m1_held_beat%0d: got ack %b grant %b expected 0 01", b, bus.m1_ack_o, bus.grant_o); end
         tick();
      end
      bus.s_ack_i = 0; bus.m0_cyc_i = 0; bus.m0_stb_i = 0;
      tick();
      tick();
      #1;
      n_checks++; if (bus.grant_o !== 2'b10) begin n_fail++; $display("FAIL lock_m1_after: got %b expected 10", bus.grant_o); end
      bus.m1_cyc_i = 0; bus.m1_stb_i = 0;
      tick();
      tick();
   endtask

   task automatic test_timeout();
      bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_we_i = 1; bus.m1_adr_i = 32'h0000_3000;
      tick();
      #1;
      n_checks++; if (bus.s_stb_o !== 1'b1 || bus.grant_o !== 2'b10) begin n_fail++; $display("FAIL to_start: got stb %b grant %b expected 1 10", bus.s_stb_o, bus.grant_o); end
      for (int unsigned i = 1; i < 4; i++) begin
         tick();
         #1;
         n_checks++; if ({bus.m1_err_o, bus.timeout_o} !== 2'b00) begin n_fail++; $display("FAIL to_early_wait%0d: got %b expected 00", i, {bus.m1_err_o, bus.timeout_o}); end
      end
      tick();
      #1;
      n_checks++; if ({bus.m1_err_o, bus.timeout_o, bus.m1_ack_o} !== 3'b110) begin n_fail++; $display("FAIL to_fire: got err/to/ack %b expected 110", {bus.m1_err_o, bus.timeout_o, bus.m1_ack_o}); end
      tick();
      bus.s_ack_i = 1;
      #1;
      n_checks++; if (bus.s_cyc_o !== 1'b0 || bus.grant_o !== 2'b00) begin n_fail++; $display("FAIL to_drain_bus: got cyc %b grant %b expected 0 00", bus.s_cyc_o, bus.grant_o); end
      n_checks++; if ({bus.m1_ack_o, bus.m1_err_o, bus.timeout_o} !== 3'b000) begin n_fail++; $display("FAIL to_late_ack: got %b expected 000", {bus.m1_ack_o, bus.m1_err_o, bus.timeout_o}); end
      bus.s_ack_i = 0;
      tick();
      tick();
      #1;
      n_checks++; if (bus.grant_o !== 2'b00) begin n_fail++; $display("FAIL to_drain_hold: got %b expected 00", bus.grant_o); end
      bus.m1_cyc_i = 0; bus.m1_stb_i = 0;
      tick();
      bus.m1_cyc_i = 1; bus.m1_stb_i = 1;
      #1;
      n_checks++; if (bus.grant_o !== 2'b00) begin n_fail++; $display("FAIL to_idle_after: got %b expected 00", bus.grant_o); end
      tick();
      #1;
      n_checks++; if (bus.grant_o !== 2'b10) begin n_fail++; $display("FAIL to_regrant: got %b expected 10", bus.grant_o); end
      bus.m1_cyc_i = 0; bus.m1_stb_i = 0; bus.m1_we_i = 0;
      tick();
      tick();
   endtask

   task automatic test_ack_boundary();
      bus.m0_cyc_i = 1; bus.m0_stb_i = 1;
      tick();
      for (int unsigned i = 1; i < 4; i++) tick();
      tick();
      bus.s_ack_i = 1; bus.s_dat_i = 32'h1234_5678;
      #1;
      n_checks++; if ({bus.m0_ack_o, bus.m0_err_o, bus.timeout_o} !== 3'b100) begin n_fail++; $display("FAIL edge_ack_wins: got ack/err/to %b expected 100", {bus.m0_ack_o, bus.m0_err_o, bus.timeout_o}); end
      n_checks++; if (bus.m0_dat_o !== 32'h1234_5678) begin n_fail++; $display("FAIL edge_dat: got %h expected 12345678", bus.m0_dat_o); end
      tick();
      bus.s_ack_i = 0;
      #1;
      n_checks++; if ({bus.m0_err_o, bus.timeout_o} !== 2'b00 || bus.grant_o !== 2'b01) begin n_fail++; $display("FAIL edge_cleared: got err/to %b grant %b expected 00 01", {bus.m0_err_o, bus.timeout_o}, bus.grant_o); end
      bus.m0_cyc_i = 0; bus.m0_stb_i = 0;
      tick();
      tick();
   endtask

   task automatic test_reset_mid();
      bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_we_i = 1; bus.m1_dat_i = 32'hDEAD_BEEF;
      tick();
      #1;
      n_checks++; if (bus.s_cyc_o !== 1'b1 || bus.grant_o !== 2'b10) begin n_fail++; $display("FAIL rst_pre: got cyc %b grant %b expected 1 10", bus.s_cyc_o, bus.grant_o); end
      bus.s_ack_i = 1;
      rst_n = 1'b0;
      #1;
      n_checks++; if (bus.s_cyc_o !== 1'b0 || bus.grant_o !== 2'b00) begin n_fail++; $display("FAIL rst_async_drop: got cyc %b grant %b expected 0 00", bus.s_cyc_o, bus.grant_o); end
      n_checks++; if ({bus.m1_ack_o, bus.m1_err_o} !== 2'b00) begin n_fail++; $display("FAIL rst_no_ack: got %b expected 00", {bus.m1_ack_o, bus.m1_err_o}); end
      tick();
      clear_inputs();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_alternate();
      logic [1:0] exp;
      logic       own;
      bus.m0_cyc_i = 1; bus.m0_stb_i = 1;
      bus.m1_cyc_i = 1; bus.m1_stb_i = 1;
      tick();
      own = 1'b0;
      for (int unsigned g = 0; g < 10; g++) begin
         exp = own ? 2'b10 : 2'b01;
         bus.s_ack_i = 1;
         #1;
         n_checks++; if (bus.grant_o !== exp) begin n_fail++; $display("FAIL alt_grant%0d: got %b expected %b", g, bus.grant_o, exp); end
         n_checks++; if ({bus.m1_ack_o, bus.m0_ack_o} !== exp) begin n_fail++; $display("FAIL alt_ack%0d: got m1/m0 ack %b expected %b", g, {bus.m1_ack_o, bus.m0_ack_o}, exp); end
         tick();
         bus.s_ack_i = 0;
         if (own) begin bus.m1_cyc_i = 0; bus.m1_stb_i = 0; end
         else begin bus.m0_cyc_i = 0; bus.m0_stb_i = 0; end
         tick();
         if (own) begin bus.m1_cyc_i = 1; bus.m1_stb_i = 1; end
         else begin bus.m0_cyc_i = 1; bus.m0_stb_i = 1; end
         #1;
         n_checks++; if (bus.grant_o !== 2'b00) begin n_fail++; $display("FAIL alt_gap%0d: got %b expected 00", g, bus.grant_o); end
         tick();
         own = !own;
      end
      clear_inputs();
      tick();
      tick();
   endtask

   initial begin
      test_reset();
      test_tie();
      test_lock();
      test_timeout();
      test_ack_boundary();
      test_reset_mid();
      test_alternate();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
